// File: rtl/mult_accumulator_if.sv
// Product-in / frame-sum-out handshake bundle for mult_accumulator.
interface mult_accumulator_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned ACC_W = 8 + $clog2(N)
);
  localparam int unsigned LEN_W = $clog2(N) + 1;

  logic [7:0]       p_in;
  logic             p_valid;
  logic             p_ready;
  logic             flush;
  logic [ACC_W-1:0] sum_out;
  logic [LEN_W-1:0] sum_len;
  logic             sum_valid;
  logic             sum_ready;

  modport master (
    output p_in, p_valid, flush, sum_ready,
    input  p_ready, sum_out, sum_len, sum_valid
  );

  modport slave (
    input  p_in, p_valid, flush, sum_ready,
    output p_ready, sum_out, sum_len, sum_valid
  );
endinterface

// File: rtl/mult_accumulator.sv
// Accumulates up to N unsigned 8-bit products per frame and presents the
// frame sum with a valid/ready handshake; flush closes a partial frame.
module mult_accumulator #(
  parameter int unsigned N     = 4,
  parameter int unsigned ACC_W = 8 + $clog2(N)
) (
  input  logic clk,
  input  logic rst,
  mult_accumulator_if.slave bus
);
  localparam int unsigned LEN_W = $clog2(N) + 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] cnt;

  logic             accept;
  logic [ACC_W-1:0] acc_next;
  logic [LEN_W-1:0] cnt_next;

  assign bus.p_ready = (state == ACCUM);

  // Running totals including any product accepted this cycle.
  always_comb begin
    accept   = 1'b0;
    acc_next = acc;
    cnt_next = cnt;
    if (bus.p_valid && (state == ACCUM)) begin
      accept   = 1'b1;
      acc_next = acc + ACC_W'(bus.p_in);
      cnt_next = cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ACCUM;
      acc           <= '0;
      cnt           <= '0;
      bus.sum_out   <= '0;
      bus.sum_len   <= '0;
      bus.sum_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          // Close on the Nth product, or on flush once at least one product is counted.
          if ((accept && (cnt_next == LEN_W'(N))) ||
              (bus.flush && (cnt_next != '0))) begin
            bus.sum_out   <= acc_next;
            bus.sum_len   <= cnt_next;
            bus.sum_valid <= 1'b1;
            acc           <= '0;
            cnt           <= '0;
            state         <= HOLD;
          end else begin
            acc <= acc_next;
            cnt <= cnt_next;
          end
        end
        HOLD: begin
          if (bus.sum_ready) begin
            bus.sum_valid <= 1'b0;
            state         <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_accumulator.sv
// Directed self-checking bench for mult_accumulator (N=4, ACC_W=10).
module tb_mult_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mult_accumulator_if #(.N(4), .ACC_W(10)) bus ();

  mult_accumulator #(.N(4), .ACC_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] p, input logic fl);
    bus.p_in    = p;
    bus.p_valid = 1'b1;
    bus.flush   = fl;
    @(posedge clk); #1;
    bus.p_valid = 1'b0;
    bus.flush   = 1'b0;
  endtask

  task automatic idle(input logic fl);
    bus.p_valid = 1'b0;
    bus.flush   = fl;
    @(posedge clk); #1;
    bus.flush   = 1'b0;
  endtask

  task automatic chk_sum(input string tag, input int s, input int l);
    chk({tag, "_valid"}, 32'(bus.sum_valid), 32'd1);
    chk({tag, "_sum"},   32'(bus.sum_out),   32'(s));
    chk({tag, "_len"},   32'(bus.sum_len),   32'(l));
    chk({tag, "_pready_hold"}, 32'(bus.p_ready), 32'd0);
  endtask

  initial begin
    bus.p_in      = '0;
    bus.p_valid   = 1'b0;
    bus.flush     = 1'b0;
    bus.sum_ready = 1'b1;

    // Reset state
    @(posedge clk); #1;
    chk("rst_pready", 32'(bus.p_ready),   32'd1);
    chk("rst_valid",  32'(bus.sum_valid), 32'd0);
    chk("rst_sum",    32'(bus.sum_out),   32'd0);
    chk("rst_len",    32'(bus.sum_len),   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame
    send(8'd6, 1'b0); send(8'd120, 1'b0); send(8'd225, 1'b0);
    chk("basic_no_early_valid", 32'(bus.sum_valid), 32'd0);
    send(8'd0, 1'b0);
    chk_sum("basic", 351, 4);
    idle(1'b0);
    chk("basic_hs_valid",  32'(bus.sum_valid), 32'd0);
    chk("basic_hs_pready", 32'(bus.p_ready),   32'd1);

    // Maximum values
    repeat (4) send(8'd225, 1'b0);
    chk_sum("max225", 900, 4);
    idle(1'b0);
    repeat (4) send(8'd255, 1'b0);
    chk_sum("max255", 1020, 4);
    idle(1'b0);

    // Zero products counted
    repeat (4) send(8'd0, 1'b0);
    chk_sum("zeros", 0, 4);
    idle(1'b0);

    // Backpressure, with p_valid and flush held during HOLD
    bus.sum_ready = 1'b0;
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
    chk_sum("bp", 10, 4);
    for (int i = 0; i < 5; i++) begin
      bus.p_in    = 8'd99;
      bus.p_valid = 1'b1;
      bus.flush   = 1'b1;
      @(posedge clk); #1;
      chk("bp_stable_sum",   32'(bus.sum_out),   32'd10);
      chk("bp_stable_len",   32'(bus.sum_len),   32'd4);
      chk("bp_stable_valid", 32'(bus.sum_valid), 32'd1);
      chk("bp_pready",       32'(bus.p_ready),   32'd0);
    end
    bus.p_valid   = 1'b0;
    bus.flush     = 1'b0;
    bus.sum_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_valid",  32'(bus.sum_valid), 32'd0);
    chk("bp_hs_pready", 32'(bus.p_ready),   32'd1);
    send(8'd1, 1'b0); send(8'd1, 1'b1);
    chk_sum("bp_after", 2, 2);
    idle(1'b0);

    // Flush after two products
    send(8'd6, 1'b0); send(8'd120, 1'b0);
    idle(1'b1);
    chk_sum("flush", 126, 2);
    idle(1'b0);

    // Flush with empty frame is ignored
    idle(1'b1);
    chk("flush_empty_valid1", 32'(bus.sum_valid), 32'd0);
    idle(1'b1);
    chk("flush_empty_valid2", 32'(bus.sum_valid), 32'd0);
    chk("flush_empty_pready", 32'(bus.p_ready),   32'd1);

    // Flush with same-cycle accept
    send(8'd6, 1'b0); send(8'd120, 1'b1);
    chk_sum("flush_acc", 126, 2);
    idle(1'b0);

    // Flush with the Nth product yields one frame
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b1);
    chk_sum("flush_nth", 10, 4);
    idle(1'b0);
    chk("flush_nth_hs", 32'(bus.sum_valid), 32'd0);
    idle(1'b0);
    chk("flush_nth_single", 32'(bus.sum_valid), 32'd0);

    // Asynchronous reset mid-frame
    send(8'd7, 1'b0); send(8'd7, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_pready", 32'(bus.p_ready),   32'd1);
    chk("arst_valid",  32'(bus.sum_valid), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    repeat (4) send(8'd1, 1'b0);
    chk_sum("arst_frame", 4, 4);
    idle(1'b0);

    // Asynchronous reset in HOLD discards the pending sum
    bus.sum_ready = 1'b0;
    repeat (4) send(8'd50, 1'b0);
    chk_sum("arst_hold_pre", 200, 4);
    #2 rst = 1'b1;
    #1;
    chk("arst_hold_valid", 32'(bus.sum_valid), 32'd0);
    chk("arst_hold_sum",   32'(bus.sum_out),   32'd0);
    chk("arst_hold_pready", 32'(bus.p_ready),  32'd1);
    #1 rst = 1'b0;
    bus.sum_ready = 1'b1;
    @(posedge clk); #1;
    send(8'd9, 1'b0); send(8'd8, 1'b1);
    chk_sum("arst_hold_after", 17, 2);
    idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
